// File: rtl/ngc_counter_sched_pkg.sv
// Shared types and fixed counter configuration for the counter scheduler.
package ngc_counter_sched_pkg;

  // Scheduler FSM encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // The attached counter always runs as a one-shot down counter that
  // stops at zero and parks at zero when reset.
  localparam logic        CNT_DIR_DOWN = 1'b1;
  localparam logic        CNT_ONE_SHOT = 1'b1;
  localparam int unsigned CNT_STEP     = 1;
  localparam int unsigned CNT_FROM     = 0;
  localparam int unsigned CNT_TO       = 0;

endpackage

// File: rtl/ngc_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above rr_ptr_i,
// wrapping around to index 0.
module ngc_rr_arbiter
  import ngc_counter_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    rr_ptr_i,
  output logic             valid_o,
  output logic [IW-1:0]    index_o
);

  // Position k steps above the pointer, wrapped into 0..N_REQ-1.
  function automatic int slot(input logic [IW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N_REQ) s = s - N_REQ;
    return s;
  endfunction

  // Scan from farthest to nearest so the nearest set request wins.
  always_comb begin
    valid_o = 1'b0;
    index_o = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_i[IW'(slot(rr_ptr_i, k))]) begin
        valid_o = 1'b1;
        index_o = IW'(slot(rr_ptr_i, k));
      end
    end
  end

endmodule

// File: rtl/ngc_counter_sched.sv
// Shares one external ngc_counter between N_REQ one-shot delay requesters.
// A round-robin winner gets the counter loaded with its delay, the counter
// runs down to zero, and the owner receives a single-cycle done pulse.
module ngc_counter_sched
  import ngc_counter_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] req_len,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic                   cnt_rst,
  output logic                   cnt_load,
  output logic [WIDTH-1:0]       cnt_load_value,
  output logic                   cnt_enb,
  output logic                   cnt_dir,
  output logic                   cnt_one_shot,
  output logic [WIDTH-1:0]       cnt_step_value,
  output logic [WIDTH-1:0]       cnt_from_value,
  output logic [WIDTH-1:0]       cnt_to_value,
  input  logic                   cnt_hit
);

  localparam int IW = $clog2(N_REQ);

  state_t          state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;

  logic            arb_valid;
  logic [IW-1:0]   arb_index;
  logic            owner_req;
  logic [N_REQ-1:0] owner_oh;

  // Pointer position just after the given owner, wrapping at N_REQ.
  function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] cur);
    if (int'(cur) == N_REQ - 1) return '0;
    return cur + 1'b1;
  endfunction

  ngc_rr_arbiter #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_arb (
    .req_i    (req),
    .rr_ptr_i (rr_ptr_q),
    .valid_o  (arb_valid),
    .index_o  (arb_index)
  );

  assign owner_req = req[owner_q];
  assign owner_oh  = {{(N_REQ-1){1'b0}}, 1'b1} << owner_q;

  // Next-state logic: arbitrate in IDLE, load once, run to hit, pulse done.
  // A dropped request in LOAD/RUN cancels and takes priority over cnt_hit.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          owner_d = arb_index;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (!owner_req) begin
          rr_ptr_d = next_ptr(owner_q);
          state_d  = IDLE;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!owner_req) begin
          rr_ptr_d = next_ptr(owner_q);
          state_d  = IDLE;
        end else if (cnt_hit) begin
          state_d = DONE;
        end
      end
      DONE: begin
        rr_ptr_d = next_ptr(owner_q);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, owner and round-robin pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Output decode from registered state and owner only; the load value is
  // the owner's delay, presented only while the load strobe is high.
  always_comb begin
    grant          = '0;
    done           = '0;
    busy           = 1'b1;
    cnt_rst        = 1'b0;
    cnt_load       = 1'b0;
    cnt_enb        = 1'b0;
    cnt_load_value = '0;
    unique case (state_q)
      IDLE: begin
        busy    = 1'b0;
        cnt_rst = 1'b1;
      end
      LOAD: begin
        grant          = owner_oh;
        cnt_load       = 1'b1;
        cnt_load_value = req_len[int'(owner_q)*WIDTH +: WIDTH];
      end
      RUN: begin
        grant   = owner_oh;
        cnt_enb = 1'b1;
      end
      DONE: begin
        grant = owner_oh;
        done  = owner_oh;
      end
      default: begin
        busy    = 1'b0;
        cnt_rst = 1'b1;
      end
    endcase
  end

  assign cnt_dir        = CNT_DIR_DOWN;
  assign cnt_one_shot   = CNT_ONE_SHOT;
  assign cnt_step_value = WIDTH'(CNT_STEP);
  assign cnt_from_value = WIDTH'(CNT_FROM);
  assign cnt_to_value   = WIDTH'(CNT_TO);

endmodule

// File: tb/tb_ngc_counter_sched.sv
// Directed bench for ngc_counter_sched with a behavioural one-shot counter.
module tb_ngc_counter_sched;
  localparam int N = 4;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_len;
  logic [N-1:0]   grant, done;
  logic           busy, cnt_rst, cnt_load, cnt_enb, cnt_dir, cnt_one_shot;
  logic [W-1:0]   cnt_load_value, cnt_step_value, cnt_from_value, cnt_to_value;
  logic           cnt_hit;
  logic [W-1:0]   cnt_q;

  logic [3:0]     a_req;
  logic [1:0]     a_ptr;
  logic           a_valid;
  logic [1:0]     a_idx;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic [N-1:0]   req;
    logic [N*W-1:0] lens;
    logic [15:0]    exp;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  ngc_counter_sched #(.N_REQ(N), .WIDTH(W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req            (req),
    .req_len        (req_len),
    .grant          (grant),
    .done           (done),
    .busy           (busy),
    .cnt_rst        (cnt_rst),
    .cnt_load       (cnt_load),
    .cnt_load_value (cnt_load_value),
    .cnt_enb        (cnt_enb),
    .cnt_dir        (cnt_dir),
    .cnt_one_shot   (cnt_one_shot),
    .cnt_step_value (cnt_step_value),
    .cnt_from_value (cnt_from_value),
    .cnt_to_value   (cnt_to_value),
    .cnt_hit        (cnt_hit)
  );

  ngc_rr_arbiter #(.N_REQ(4)) u_arb_ut (
    .req_i    (a_req),
    .rr_ptr_i (a_ptr),
    .valid_o  (a_valid),
    .index_o  (a_idx)
  );

  // Behavioural one-shot down counter standing in for ngc_counter.
  always @(posedge clk) begin
    if (cnt_rst)                            cnt_q <= cnt_from_value;
    else if (cnt_load)                      cnt_q <= cnt_load_value;
    else if (cnt_enb && cnt_q != cnt_to_value) cnt_q <= cnt_q - cnt_step_value;
  end
  assign cnt_hit = (cnt_q == cnt_to_value);

  wire [15:0] outs_act = {grant, done, busy, cnt_rst, cnt_load, cnt_enb, cnt_load_value};

  function automatic logic [15:0] pk(input logic [3:0] g, input logic [3:0] d, input logic b,
                                     input logic r, input logic l, input logic e,
                                     input logic [3:0] v);
    return {g, d, b, r, l, e, v};
  endfunction
  function automatic logic [15:0] e_idle();
    return pk(4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
  endfunction
  function automatic logic [15:0] e_load(input logic [3:0] oh, input logic [3:0] v);
    return pk(oh, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, v);
  endfunction
  function automatic logic [15:0] e_run(input logic [3:0] oh);
    return pk(oh, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0);
  endfunction
  function automatic logic [15:0] e_done(input logic [3:0] oh);
    return pk(oh, oh, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic void add(input logic [3:0] r, input logic [15:0] lens, input logic [15:0] exp);
    vec_t v;
    v.req  = r;
    v.lens = lens;
    v.exp  = exp;
    tbl.push_back(v);
  endfunction

  // One clock cycle: drive inputs just after the edge, sample mid-cycle.
  task automatic step(input string name, input logic [3:0] r, input logic [15:0] lens,
                      input logic [15:0] exp);
    @(posedge clk);
    #1;
    req     = r;
    req_len = lens;
    #3;
    check(name, 32'(outs_act), 32'(exp));
  endtask

  initial begin
    logic [3:0] oh;
    logic       ev;
    logic [1:0] ei;
    logic [3:0] rv;

    req     = '0;
    req_len = '0;
    a_req   = '0;
    a_ptr   = '0;
    #1 rst_n = 1'b0;
    #1;
    check("reset_state", 32'(outs_act), 32'(e_idle()));
    check("const_dir", 32'(cnt_dir), 32'd1);
    check("const_one_shot", 32'(cnt_one_shot), 32'd1);
    check("const_step", 32'(cnt_step_value), 32'd1);
    check("const_from", 32'(cnt_from_value), 32'd0);
    check("const_to", 32'(cnt_to_value), 32'd0);

    // Arbiter alone: every request pattern against every pointer.
    for (int r = 0; r < 16; r++) begin
      for (int p = 0; p < 4; p++) begin
        rv    = 4'(r);
        a_req = rv;
        a_ptr = 2'(p);
        #1;
        ev = 1'b0;
        ei = 2'd0;
        for (int k = 0; k < 4; k++) begin
          if (!ev && rv[(p + k) % 4]) begin
            ev = 1'b1;
            ei = 2'((p + k) % 4);
          end
        end
        check($sformatf("arb_r%0d_p%0d", r, p), 32'({a_valid, a_idx}), 32'({ev, ei}));
      end
    end

    // Fairness from reset: all four requesting, length 2 each, five grants.
    for (int g = 0; g < 5; g++) begin
      oh = 4'(1 << (g % 4));
      add(4'b1111, 16'h2222, e_idle());
      add(4'b1111, 16'h2222, e_load(oh, 4'd2));
      for (int k = 0; k < 3; k++) add(4'b1111, 16'h2222, e_run(oh));
      add(4'b1111, 16'h2222, e_done(oh));
    end
    // Single request on 0 with length 5: done in cycle 8, idle in cycle 9.
    add(4'b0001, 16'h0005, e_idle());
    add(4'b0001, 16'h0005, e_load(4'b0001, 4'd5));
    for (int k = 0; k < 6; k++) add(4'b0001, 16'h0005, e_run(4'b0001));
    add(4'b0001, 16'h0005, e_done(4'b0001));
    // Zero length on requester 2: one RUN cycle, done in cycle 3.
    add(4'b0100, 16'h0005, e_idle());
    add(4'b0100, 16'h0005, e_load(4'b0100, 4'd0));
    add(4'b0100, 16'h0005, e_run(4'b0100));
    add(4'b0100, 16'h0005, e_done(4'b0100));
    add(4'b0000, 16'h0005, e_idle());

    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step("idle0", 4'b0000, 16'h0000, e_idle());
    step("idle1", 4'b0000, 16'h0000, e_idle());

    foreach (tbl[i]) step($sformatf("tbl%0d", i), tbl[i].req, tbl[i].lens, tbl[i].exp);

    // Asynchronous reset in the middle of a run on requester 3.
    step("rs_c0", 4'b1000, 16'h9000, e_idle());
    step("rs_c1", 4'b1000, 16'h9000, e_load(4'b1000, 4'd9));
    step("rs_c2", 4'b1000, 16'h9000, e_run(4'b1000));
    step("rs_c3", 4'b1000, 16'h9000, e_run(4'b1000));
    #1;
    rst_n = 1'b0;
    req   = '0;
    #1;
    check("rs_async", 32'(outs_act), 32'(e_idle()));
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    step("rs_r0", 4'b1001, 16'h9000, e_idle());
    step("rs_r1_ptr0", 4'b0000, 16'h9000, e_load(4'b0001, 4'd0));
    step("rs_r2_cancel_load", 4'b0000, 16'h9000, e_idle());

    // Cancel of requester 1 mid-run, requester 3 waiting.
    step("cx_c0", 4'b0010, 16'h10A0, e_idle());
    step("cx_c1", 4'b0010, 16'h10A0, e_load(4'b0010, 4'hA));
    step("cx_c2", 4'b0010, 16'h10A0, e_run(4'b0010));
    step("cx_c3", 4'b1010, 16'h10A0, e_run(4'b0010));
    step("cx_c4", 4'b1010, 16'h10A0, e_run(4'b0010));
    step("cx_c5", 4'b1000, 16'h10A0, e_run(4'b0010));
    step("cx_c6", 4'b1000, 16'h10A0, e_idle());
    step("cx_c7", 4'b1000, 16'h10A0, e_load(4'b1000, 4'd1));
    step("cx_c8", 4'b1000, 16'h10A0, e_run(4'b1000));
    step("cx_c9", 4'b1000, 16'h10A0, e_run(4'b1000));
    step("cx_c10", 4'b1000, 16'h10A0, e_done(4'b1000));
    step("cx_c11", 4'b0000, 16'h10A0, e_idle());

    // Maximum length 15: done in cycle 18.
    step("mx_c0", 4'b0001, 16'h000F, e_idle());
    step("mx_c1", 4'b0001, 16'h000F, e_load(4'b0001, 4'hF));
    for (int c = 2; c <= 17; c++) step($sformatf("mx_c%0d", c), 4'b0001, 16'h000F, e_run(4'b0001));
    step("mx_c18", 4'b0001, 16'h000F, e_done(4'b0001));
    step("mx_c19", 4'b0000, 16'h000F, e_idle());

    // Same again, but the request drops in the cycle the hit appears.
    step("rc_c0", 4'b0001, 16'h000F, e_idle());
    step("rc_c1", 4'b0001, 16'h000F, e_load(4'b0001, 4'hF));
    for (int c = 2; c <= 16; c++) step($sformatf("rc_c%0d", c), 4'b0001, 16'h000F, e_run(4'b0001));
    step("rc_c17", 4'b0000, 16'h000F, e_run(4'b0001));
    check("rc_c17_hit", 32'(cnt_hit), 32'd1);
    step("rc_c18_no_done", 4'b0000, 16'h000F, e_idle());
    step("rc_c19", 4'b0000, 16'h000F, e_idle());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
